// File: rtl/ecp5pll_phase_ctrl.sv
// ecp5pll_phase_ctrl
// Sequences the ECP5 EHXPLLL dynamic phase-adjust port. A command (step or
// register-load) is taken over a valid/ready handshake. The block then drives
// PHASESEL/PHASEDIR, followed by the PHASESTEP or PHASELOADREG low pulses,
// with setup, pulse-width and settle timing. It also keeps a wrapping
// two's-complement phase offset for each of the four PLL outputs.
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   pll_locked             PLL LOCK (asynchronous, synchronized here)
//   req_valid/req_ready    command handshake
//   req_sel/req_dir        target output and direction (1 = advance)
//   req_steps/req_load     step count, or PHASELOADREG request
//   busy/done/err          status; done/err are one-cycle pulses
//   phasesel..phaseloadreg PLL phase-control pins (strobes idle high)
//   pos_rd_sel/pos_rd_data accumulator read-back
module ecp5pll_phase_ctrl #(
  parameter int C_pulse_cycles  = 4,
  parameter int C_settle_cycles = 16,
  parameter int C_step_bits     = 8,
  parameter int C_pos_bits      = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   pll_locked,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [1:0]             req_sel,
  input  logic                   req_dir,
  input  logic [C_step_bits-1:0] req_steps,
  input  logic                   req_load,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  output logic [1:0]             phasesel,
  output logic                   phasedir,
  output logic                   phasestep,
  output logic                   phaseloadreg,
  input  logic [1:0]             pos_rd_sel,
  output logic [C_pos_bits-1:0]  pos_rd_data
);

  // One shared down-counter times setup (2), pulse and settle phases.
  localparam int C_cnt_max0 = (C_pulse_cycles > C_settle_cycles) ? C_pulse_cycles : C_settle_cycles;
  localparam int C_cnt_max  = (C_cnt_max0 > 2) ? C_cnt_max0 : 2;
  localparam int C_cnt_bits = $clog2(C_cnt_max + 1);

  localparam logic [C_cnt_bits-1:0] C_setup_ld  = C_cnt_bits'(1);
  localparam logic [C_cnt_bits-1:0] C_pulse_ld  = C_cnt_bits'(C_pulse_cycles - 1);
  localparam logic [C_cnt_bits-1:0] C_settle_ld = C_cnt_bits'(C_settle_cycles - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETUP  = 3'd1,
    S_PULSE  = 3'd2,
    S_LOAD   = 3'd3,
    S_SETTLE = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  state_t                  state_q, state_d;
  logic [C_cnt_bits-1:0]   cnt_q, cnt_d;
  logic [C_step_bits-1:0]  rem_q, rem_d;
  logic [1:0]              sel_q, sel_d;
  logic                    dir_q, dir_d;
  logic                    load_q, load_d;
  logic                    err_d;
  logic                    lock_meta_q, lock_s_q;
  logic                    phasestep_q, phaseloadreg_q;
  logic                    busy_q, done_q, err_q;
  logic [C_pos_bits-1:0]   acc_q [4];
  logic [C_pos_bits-1:0]   acc_d [4];

  // Two-flop synchronizer for the asynchronous PLL lock signal.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_meta_q <= 1'b0;
      lock_s_q    <= 1'b0;
    end else begin
      lock_meta_q <= pll_locked;
      lock_s_q    <= lock_meta_q;
    end
  end

  assign req_ready = (state_q == S_IDLE) && lock_s_q;

  // Next-state, counters and accumulator update.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    sel_d   = sel_q;
    dir_d   = dir_q;
    load_d  = load_q;
    err_d   = 1'b0;
    for (int i = 0; i < 4; i++) begin
      acc_d[i] = acc_q[i];
    end
    case (state_q)
      S_IDLE: begin
        if (req_valid && req_ready) begin
          sel_d   = req_sel;
          dir_d   = req_dir;
          load_d  = req_load;
          rem_d   = req_steps;
          cnt_d   = C_setup_ld;
          state_d = S_SETUP;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SETUP: begin
        if (!lock_s_q) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - C_cnt_bits'(1);
        end else if (load_q) begin
          cnt_d   = C_pulse_ld;
          state_d = S_LOAD;
        end else if (rem_q == '0) begin
          state_d = S_DONE;
        end else begin
          cnt_d   = C_pulse_ld;
          state_d = S_PULSE;
        end
      end
      S_PULSE: begin
        // Lock loss wins over pulse completion, so an aborted pulse is never counted.
        if (!lock_s_q) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - C_cnt_bits'(1);
        end else begin
          acc_d[sel_q] = dir_q ? (acc_q[sel_q] - C_pos_bits'(1)) : (acc_q[sel_q] + C_pos_bits'(1));
          rem_d        = rem_q - C_step_bits'(1);
          cnt_d        = C_settle_ld;
          state_d      = S_SETTLE;
        end
      end
      S_LOAD: begin
        if (!lock_s_q) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - C_cnt_bits'(1);
        end else begin
          acc_d[sel_q] = '0;
          rem_d        = '0;
          cnt_d        = C_settle_ld;
          state_d      = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (!lock_s_q) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - C_cnt_bits'(1);
        end else if (rem_q != '0) begin
          cnt_d   = C_pulse_ld;
          state_d = S_PULSE;
        end else begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        // The command has already completed; done is reported, never err.
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, command registers, accumulators and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      rem_q          <= '0;
      sel_q          <= 2'b00;
      dir_q          <= 1'b0;
      load_q         <= 1'b0;
      phasestep_q    <= 1'b1;
      phaseloadreg_q <= 1'b1;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      err_q          <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        acc_q[i] <= '0;
      end
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      rem_q          <= rem_d;
      sel_q          <= sel_d;
      dir_q          <= dir_d;
      load_q         <= load_d;
      // Strobes follow the next state so they are low exactly while in PULSE/LOAD.
      phasestep_q    <= (state_d != S_PULSE);
      phaseloadreg_q <= (state_d != S_LOAD);
      busy_q         <= (state_d != S_IDLE);
      done_q         <= (state_d == S_DONE);
      err_q          <= err_d;
      for (int i = 0; i < 4; i++) begin
        acc_q[i] <= acc_d[i];
      end
    end
  end

  assign phasesel     = sel_q;
  assign phasedir     = dir_q;
  assign phasestep    = phasestep_q;
  assign phaseloadreg = phaseloadreg_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign err          = err_q;
  assign pos_rd_data  = acc_q[pos_rd_sel];

endmodule

// File: tb/tb_ecp5pll_phase_ctrl.sv
module tb_ecp5pll_phase_ctrl;

  localparam int P  = 4;
  localparam int S  = 16;
  localparam int PS = P + S;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       pll_locked;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] req_sel;
  logic       req_dir;
  logic [7:0] req_steps;
  logic       req_load;
  logic       busy, done, err;
  logic [1:0] phasesel;
  logic       phasedir, phasestep, phaseloadreg;
  logic [1:0] pos_rd_sel;
  logic [7:0] pos_rd_data;

  int checks   = 0;
  int failures = 0;

  int done_cyc, err_cyc, pat_err, sel_err, rdy_err, err_strobe_ok;

  always #5 clk = ~clk;

  ecp5pll_phase_ctrl dut (
    .clk(clk), .rst_n(rst_n), .pll_locked(pll_locked),
    .req_valid(req_valid), .req_ready(req_ready), .req_sel(req_sel),
    .req_dir(req_dir), .req_steps(req_steps), .req_load(req_load),
    .busy(busy), .done(done), .err(err),
    .phasesel(phasesel), .phasedir(phasedir), .phasestep(phasestep),
    .phaseloadreg(phaseloadreg), .pos_rd_sel(pos_rd_sel), .pos_rd_data(pos_rd_data)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic read_pos(input logic [1:0] sel, output logic [7:0] val);
    pos_rd_sel = sel;
    #1;
    val = pos_rd_data;
  endtask

  // Issue one command and watch it cycle by cycle (cycle 0 = accept cycle).
  // Expected strobe pattern: pulse k occupies cycles 3+k*PS .. 3+k*PS+P-1.
  task automatic run_cmd(input logic [1:0] sel, input logic dir, input logic [7:0] steps,
                         input logic load, input bit keep_valid, input int drop_cyc,
                         input int exp_steps, input int exp_loads, input int budget);
    bit exp_step_low, exp_load_low;
    done_cyc = 0; err_cyc = 0; pat_err = 0; sel_err = 0; rdy_err = 0; err_strobe_ok = 0;
    @(negedge clk);
    check_eq("ready_before_req", {31'd0, req_ready}, 32'd1);
    req_sel = sel; req_dir = dir; req_steps = steps; req_load = load; req_valid = 1'b1;
    @(posedge clk);
    #1;
    if (!keep_valid) req_valid = 1'b0;
    for (int cyc = 1; cyc <= budget; cyc++) begin
      @(negedge clk);
      if (cyc == drop_cyc) pll_locked = 1'b0;
      exp_step_low = (cyc >= 3) && (((cyc - 3) / PS) < exp_steps) && (((cyc - 3) % PS) < P);
      exp_load_low = (cyc >= 3) && (((cyc - 3) / PS) < exp_loads) && (((cyc - 3) % PS) < P);
      if (err) begin
        err_cyc = cyc;
        err_strobe_ok = (phasestep && phaseloadreg) ? 1 : 0;
        break;
      end
      if (phasestep !== !exp_step_low) pat_err++;
      if (phaseloadreg !== !exp_load_low) pat_err++;
      if (phasesel !== sel || phasedir !== dir) sel_err++;
      if (req_ready) rdy_err++;
      if (done) begin
        done_cyc = cyc;
        req_valid = 1'b0;
        break;
      end
    end
  endtask

  logic [7:0] pv;
  int extra_busy;

  initial begin
    rst_n = 1'b0; pll_locked = 1'b0; req_valid = 1'b0; req_sel = 2'b00;
    req_dir = 1'b0; req_steps = 8'd0; req_load = 1'b0; pos_rd_sel = 2'b00;
    #23;
    check_eq("rst_phasestep", {31'd0, phasestep}, 32'd1);
    check_eq("rst_phaseloadreg", {31'd0, phaseloadreg}, 32'd1);
    check_eq("rst_status", {29'd0, busy, done, err}, 32'd0);
    check_eq("rst_sel_dir", {29'd0, phasesel, phasedir}, 32'd0);
    check_eq("rst_ready", {31'd0, req_ready}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      read_pos(2'(i), pv);
      check_eq("rst_pos", {24'd0, pv}, 32'd0);
    end

    @(negedge clk);
    rst_n = 1'b1; pll_locked = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("ready_after_lock", {31'd0, req_ready}, 32'd1);

    // 3 delay steps on CLKOS2
    run_cmd(2'b01, 1'b0, 8'd3, 1'b0, 1'b0, 0, 3, 0, 200);
    check_eq("s3_done_cyc", done_cyc, 32'd63);
    check_eq("s3_pattern", pat_err, 32'd0);
    check_eq("s3_sel_stable", sel_err, 32'd0);
    check_eq("s3_ready_busy", rdy_err, 32'd0);
    read_pos(2'b01, pv);
    check_eq("s3_pos", {24'd0, pv}, 32'd3);
    @(negedge clk);
    check_eq("s3_busy_after", {31'd0, busy}, 32'd0);

    // 5 advance steps on CLKOS2: 3 - 5 = -2
    run_cmd(2'b01, 1'b1, 8'd5, 1'b0, 1'b0, 0, 5, 0, 300);
    check_eq("a5_done_cyc", done_cyc, 32'd103);
    check_eq("a5_pattern", pat_err, 32'd0);
    check_eq("a5_sel_stable", sel_err, 32'd0);
    read_pos(2'b01, pv);
    check_eq("a5_pos", {24'd0, pv}, 32'hFE);

    // 10 steps on CLKOP, then load (steps ignored)
    run_cmd(2'b11, 1'b0, 8'd10, 1'b0, 1'b0, 0, 10, 0, 400);
    check_eq("op10_done_cyc", done_cyc, 32'd203);
    read_pos(2'b11, pv);
    check_eq("op10_pos", {24'd0, pv}, 32'd10);
    run_cmd(2'b11, 1'b0, 8'd7, 1'b1, 1'b0, 0, 0, 1, 100);
    check_eq("load_done_cyc", done_cyc, 32'd23);
    check_eq("load_pattern", pat_err, 32'd0);
    read_pos(2'b11, pv);
    check_eq("load_pos", {24'd0, pv}, 32'd0);
    read_pos(2'b01, pv);
    check_eq("load_other_pos", {24'd0, pv}, 32'hFE);

    // zero steps with valid held through the command
    run_cmd(2'b10, 1'b1, 8'd0, 1'b0, 1'b1, 0, 0, 0, 50);
    check_eq("z_done_cyc", done_cyc, 32'd3);
    check_eq("z_pattern", pat_err, 32'd0);
    check_eq("z_ready_busy", rdy_err, 32'd0);
    extra_busy = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (busy || done) extra_busy++;
    end
    check_eq("z_single_cmd", extra_busy, 32'd0);
    read_pos(2'b10, pv);
    check_eq("z_pos", {24'd0, pv}, 32'd0);

    // lock lost during second pulse of a 4-step request
    run_cmd(2'b00, 1'b0, 8'd4, 1'b0, 1'b0, 24, 4, 0, 200);
    check_eq("ab_err_cyc", err_cyc, 32'd27);
    check_eq("ab_no_done", done_cyc, 32'd0);
    check_eq("ab_strobes_high", err_strobe_ok, 32'd1);
    check_eq("ab_pattern", pat_err, 32'd0);
    check_eq("ab_sel_hold", {29'd0, phasesel, phasedir}, 32'd0);
    read_pos(2'b00, pv);
    check_eq("ab_pos", {24'd0, pv}, 32'd1);
    @(negedge clk);
    check_eq("ab_err_pulse", {30'd0, err, busy}, 32'd0);
    extra_busy = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (req_ready) extra_busy++;
    end
    check_eq("ab_ready_unlocked", extra_busy, 32'd0);
    pll_locked = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("ab_ready_relock", {31'd0, req_ready}, 32'd1);

    // wrap: 2 then 255 more steps on CLKOS3 -> 257 mod 256 = 1
    run_cmd(2'b10, 1'b0, 8'd2, 1'b0, 1'b0, 0, 2, 0, 100);
    check_eq("w2_done_cyc", done_cyc, 32'd43);
    run_cmd(2'b10, 1'b0, 8'd255, 1'b0, 1'b0, 0, 255, 0, 6000);
    check_eq("w255_done_cyc", done_cyc, 32'd5103);
    check_eq("w255_pattern", pat_err, 32'd0);
    read_pos(2'b10, pv);
    check_eq("w255_pos", {24'd0, pv}, 32'd1);

    // reset in the middle of a command
    run_cmd(2'b01, 1'b0, 8'd3, 1'b0, 1'b0, 0, 3, 0, 5);
    rst_n = 1'b0;
    #1;
    check_eq("mr_strobes", {30'd0, phasestep, phaseloadreg}, 32'd3);
    check_eq("mr_status", {27'd0, busy, done, err, phasesel}, 32'd0);
    read_pos(2'b01, pv);
    check_eq("mr_pos", {24'd0, pv}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ecp5pll_phase_ctrl.md
Name: ecp5pll_phase_ctrl

Overview:
- Controller for the dynamic phase-adjust port of the ECP5 EHXPLLL.
- Accepts step/load commands over a valid/ready handshake and drives PHASESEL, PHASEDIR, PHASESTEP and PHASELOADREG with the required setup, pulse and settle timing.
- Tracks the accumulated phase offset of each PLL output.
- Runs in the PLL's reference or system clock domain; used for board-level skew tuning, e.g. SDRAM or video clock phase.

Parameters:
- C_pulse_cycles, 4: PHASESTEP/PHASELOADREG low width in clocks (>=1).
- C_settle_cycles, 16: high time after each pulse before the next action (>=1).
- C_step_bits, 8: width of the per-request step count.
- C_pos_bits, 8: width of each per-output phase accumulator, two's complement, wraps.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous reset, active low.
- pll_locked  in  1  PLL LOCK, asynchronous to clk.
- req_valid  in  1  command valid.
- req_ready  out  1  command accepted when valid&ready.
- req_sel  in  2  target output: 00 CLKOS, 01 CLKOS2, 10 CLKOS3, 11 CLKOP.
- req_dir  in  1  0 = delay (+1 per step), 1 = advance (-1 per step).
- req_steps  in  C_step_bits  number of steps.
- req_load  in  1  1 = PHASELOADREG pulse instead of steps.
- busy  out  1  command in progress.
- done  out  1  one-cycle pulse on normal completion.
- err  out  1  one-cycle pulse on abort (lock loss).
- phasesel  out  2  to PLL PHASESEL[1:0].
- phasedir  out  1  to PLL PHASEDIR.
- phasestep  out  1  to PLL PHASESTEP, idle high.
- phaseloadreg  out  1  to PLL PHASELOADREG, idle high.
- pos_rd_sel  in  2  accumulator read select, same encoding as req_sel.
- pos_rd_data  out  C_pos_bits  selected accumulator, combinational mux of registers.

Behaviour:
- Reset values (async, rst_n low):
  - phasesel=00, phasedir=0, phasestep=1, phaseloadreg=1.
  - busy=0, done=0, err=0, all four accumulators=0.
  - State IDLE; lock synchronizer cleared.
- pll_locked passes through a 2-FF synchronizer to give lock_s.
- req_ready = (state==IDLE) & lock_s. No command is accepted while unlocked.
- Accept cycle 0: latch sel, dir, steps, load into registers. Drive phasesel/phasedir from the latched values; they stay stable until return to IDLE. busy=1 from cycle 1.
- States and transitions:
  - IDLE: on accept, go to SETUP.
  - SETUP: 2 cycles (cycles 1-2).
    - If load: go to LOAD.
    - Else if steps==0: go to DONE.
    - Else: go to PULSE.
  - PULSE: phasestep=0 for C_pulse_cycles. On exit, phasestep returns to 1 and the accumulator[sel] updates by +1 (dir=0) or -1 (dir=1), modulo 2^C_pos_bits. Remaining count decrements. Go to SETTLE.
  - LOAD: phaseloadreg=0 for C_pulse_cycles. On exit, accumulator[sel] is cleared to 0. Go to SETTLE with remaining=0.
  - SETTLE: C_settle_cycles with both strobes high. Then go to PULSE if remaining!=0, else DONE.
  - DONE: 1 cycle, done=1, busy=0 in the following cycle. Go to IDLE.
- Timing for N>0 steps with defaults:
  - First phasestep low in cycles 3-6.
  - Last settle ends at cycle 2+N*(P+S).
  - done=1 in cycle 3+N*(P+S).
- steps==0 and load==0: no strobes; done in cycle 3.
- load takes priority over steps; steps are ignored when load=1.
- Lock loss: lock_s=0 in any non-IDLE state.
  - Abort on the next edge: strobes forced high, err=1 for one cycle, no done, go to IDLE.
  - An in-flight pulse does not update the accumulator.
  - phasesel/phasedir hold their last values.
- req_valid while busy: ignored, ready=0; no queuing.
- Mid-operation rst_n assertion: immediate return to reset values, strobes high.
- Counters for pulse/settle are sized to clog2 of max(parameter)+1.

Test Plan:
- Reset, pll_locked=1 for 3 clocks -> ready=1. Request sel=01, dir=0, steps=3 -> 3 phasestep low pulses of 4 cycles, 16 high between. phasesel=01 throughout. done at cycle 63. pos[01]=3.
- Same with dir=1, steps=5 starting from pos=3 -> pos[01]=-2 (0xFE). done at cycle 103.
- Request sel=11, load=1, steps=7 after 10 steps on CLKOP -> one phaseloadreg pulse, no phasestep pulses, pos[11]=0. done at cycle 23.
- Drop pll_locked during the 2nd pulse of a 4-step request -> err pulse within 3 clocks of the drop. Strobes high. pos shows 1 step. ready=0 until relocked.
- steps=0, load=0 -> no strobe activity, done at cycle 3. Also req_valid held while busy -> exactly one command executed.
- pos wrap: 255 steps of dir=0 from pos=2 -> pos=1.
